arp_requester: RTL and testbench

- Initiator side of ARP: on request, resolves a target IPv4 address to a MAC address.
- Writes a 42-byte ARP request frame into the TX packet buffer, then pulses transmit.
- Scans RX-buffer packets for the matching ARP reply and returns the sender MAC.
- Retransmits on timeout up to a fixed retry count.
- Sits beside the ARP responder on the same mac_clk packet-buffer interfaces; RX-buffer arbitration is external.

---
 rtl/arp_requester_pkg.sv | 81 ++++++++
 rtl/arp_req_frame.sv | 35 +++
 rtl/arp_requester.sv | 196 +++++++++++++++++++
 tb/tb_arp_requester.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arp_requester_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arp_requester_pkg
// Purpose  : ARP frame offsets, protocol constants, state encoding and byte
//            helpers shared by the ARP requester and its frame generator.
// Revision : 1.0 - initial release
// ============================================================================
package arp_requester_pkg;

    localparam logic [5:0]  c_OFF_ETHERTYPE = 6'd12;
    localparam logic [5:0]  c_OFF_OPER      = 6'd20;
    localparam logic [5:0]  c_OFF_SHA       = 6'd22;
    localparam logic [5:0]  c_OFF_SPA       = 6'd28;
    localparam logic [5:0]  c_OFF_THA       = 6'd32;
    localparam logic [5:0]  c_OFF_TPA       = 6'd38;
    localparam logic [5:0]  c_FRAME_LEN     = 6'd42;
    localparam logic [5:0]  c_LAST_ADDR     = c_FRAME_LEN - 6'd1;

    localparam logic [15:0] c_ETHERTYPE_ARP = 16'h0806;
    localparam logic [15:0] c_OPER_REQ      = 16'd1;
    localparam logic [15:0] c_OPER_REP      = 16'd2;

    localparam logic [3:0]  c_ST_IDLE       = 4'd0;
    localparam logic [3:0]  c_ST_TX_WRITE   = 4'd1;
    localparam logic [3:0]  c_ST_TX_NEXT    = 4'd2;
    localparam logic [3:0]  c_ST_WAIT_REPLY = 4'd3;
    localparam logic [3:0]  c_ST_RX_CHECK   = 4'd4;
    localparam logic [3:0]  c_ST_RX_MAC     = 4'd5;
    localparam logic [3:0]  c_ST_RX_RELEASE = 4'd6;
    localparam logic [3:0]  c_ST_DONE_OK    = 4'd7;
    localparam logic [3:0]  c_ST_DONE_FAIL  = 4'd8;

    function automatic logic [7:0] mac_byte(input logic [47:0] mac, input int idx);
        return 8'(mac >> (8 * (5 - idx)));
    endfunction

    function automatic logic [7:0] ip_byte(input logic [31:0] ip, input int idx);
        return 8'(ip >> (8 * (3 - idx)));
    endfunction

    // Fixed ARP header bytes 12..21: ethertype, HTYPE=1, PTYPE=0800, HLEN, PLEN, OPER.
    function automatic logic [7:0] arp_hdr_byte(input logic [5:0] addr, input logic [15:0] oper);
        logic [7:0] b;
        b = 8'h00;
        case (addr)
            c_OFF_ETHERTYPE:         b = c_ETHERTYPE_ARP[15:8];
            c_OFF_ETHERTYPE + 6'd1:  b = c_ETHERTYPE_ARP[7:0];
            6'd15:                   b = 8'h01;
            6'd16:                   b = 8'h08;
            6'd18:                   b = 8'h06;
            6'd19:                   b = 8'h04;
            c_OFF_OPER:              b = oper[15:8];
            c_OFF_OPER + 6'd1:       b = oper[7:0];
            default:                 b = 8'h00;
        endcase
        return b;
    endfunction

    // Expected reply byte at a checked offset (header, SPA, TPA).
    function automatic logic [7:0] arp_rx_expected(input logic [5:0]  addr,
                                                   input logic [31:0] tgt_ip,
                                                   input logic [31:0] own_ip);
        if (addr < c_OFF_SHA)
            return arp_hdr_byte(addr, c_OPER_REP);
        else if (addr < c_OFF_THA)
            return ip_byte(tgt_ip, int'(addr) - int'(c_OFF_SPA));
        else
            return ip_byte(own_ip, int'(addr) - int'(c_OFF_TPA));
    endfunction

    function automatic logic [5:0] arp_next_check(input logic [5:0] addr);
        if (addr == c_OFF_OPER + 6'd1)
            return c_OFF_SPA;
        else if (addr == c_OFF_SPA + 6'd3)
            return c_OFF_TPA;
        else
            return addr + 6'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/arp_req_frame.sv
`default_nettype none
// ============================================================================
// Module   : arp_req_frame
// Purpose  : Combinational byte generator for the 42-byte ARP request frame.
// Revision : 1.0 - initial release
// ============================================================================
module arp_req_frame (
    input  logic [5:0]  i_addr,
    input  logic [47:0] i_my_mac,
    input  logic [31:0] i_my_ip,
    input  logic [31:0] i_target_ip,
    output logic [7:0]  o_byte
);
    import arp_requester_pkg::*;

    always_comb begin
        o_byte = 8'h00;
        if (i_addr < 6'd6)
            o_byte = 8'hFF;
        else if (i_addr < c_OFF_ETHERTYPE)
            o_byte = mac_byte(i_my_mac, int'(i_addr) - 6);
        else if (i_addr < c_OFF_SHA)
            o_byte = arp_hdr_byte(i_addr, c_OPER_REQ);
        else if (i_addr < c_OFF_SPA)
            o_byte = mac_byte(i_my_mac, int'(i_addr) - int'(c_OFF_SHA));
        else if (i_addr < c_OFF_THA)
            o_byte = ip_byte(i_my_ip, int'(i_addr) - int'(c_OFF_SPA));
        else if (i_addr < c_OFF_TPA)
            o_byte = 8'h00;
        else if (i_addr < c_FRAME_LEN)
            o_byte = ip_byte(i_target_ip, int'(i_addr) - int'(c_OFF_TPA));
    end

endmodule
`default_nettype wire

// File: rtl/arp_requester.sv
`default_nettype none
// ============================================================================
// Module   : arp_requester
// Purpose  : ARP initiator - transmits a request, scans RX packets for the
//            matching reply, retries on timeout and returns the sender MAC.
// Revision : 1.0 - initial release
// ============================================================================
module arp_requester #(
    parameter int TIMEOUT_CYCLES = 12500000,
    parameter int MAX_RETRIES    = 3
) (
    input  logic        mac_clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic [31:0] target_ip,
    input  logic [47:0] myMAC,
    input  logic [31:0] myIP,
    output logic        busy,
    output logic        done,
    output logic        ok,
    output logic [47:0] resolved_mac,
    output logic [7:0]  packet_out,
    output logic [5:0]  packet_out_addr,
    output logic        packet_out_we,
    output logic        packet_xmit,
    input  logic        packet_ready,
    output logic [5:0]  packet_read_addr,
    input  logic [7:0]  packet_data,
    output logic        done_with_packet
);
    import arp_requester_pkg::*;

    localparam logic [23:0] c_TIMER_LAST = 24'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  c_RETRY_MAX  = 8'(MAX_RETRIES);
    localparam logic [5:0]  c_MAC_LAST   = c_OFF_SHA + 6'd5;

    logic [3:0]  r_state;
    logic [3:0]  w_next_state;
    logic [5:0]  r_tx_addr;
    logic [5:0]  r_rd_addr;
    logic [1:0]  r_wait;
    logic [23:0] r_timer;
    logic [7:0]  r_retry;
    logic [31:0] r_target_ip;
    logic        r_match;
    logic        r_ok;
    logic [47:0] r_mac;
    logic [7:0]  w_tx_byte;
    logic        w_expired;
    logic        w_retry_left;
    logic        w_rx_valid;
    logic        w_rx_byte_ok;
    logic        w_timing;
    logic        w_restart;

    arp_req_frame u_frame (
        .i_addr      (r_tx_addr),
        .i_my_mac    (myMAC),
        .i_my_ip     (myIP),
        .i_target_ip (r_target_ip),
        .o_byte      (w_tx_byte)
    );

    assign w_expired    = (r_timer == c_TIMER_LAST);
    assign w_retry_left = (r_retry < c_RETRY_MAX);
    // RX data lags the read address by two cycles; compare on the third.
    assign w_rx_valid   = (r_wait == 2'd2);
    assign w_rx_byte_ok = (packet_data == arp_rx_expected(r_rd_addr, r_target_ip, myIP));
    assign w_timing     = (r_state == c_ST_WAIT_REPLY) || (r_state == c_ST_RX_CHECK) ||
                          (r_state == c_ST_RX_MAC)     || (r_state == c_ST_RX_RELEASE);
    assign w_restart    = (w_next_state == c_ST_TX_WRITE) &&
                          ((r_state == c_ST_WAIT_REPLY) || (r_state == c_ST_RX_RELEASE));

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE:       if (req) w_next_state = c_ST_TX_WRITE;
            c_ST_TX_WRITE:   w_next_state = c_ST_TX_NEXT;
            c_ST_TX_NEXT:    w_next_state = (r_tx_addr == c_LAST_ADDR) ? c_ST_WAIT_REPLY : c_ST_TX_WRITE;
            c_ST_WAIT_REPLY: begin
                if (w_expired)
                    w_next_state = w_retry_left ? c_ST_TX_WRITE : c_ST_DONE_FAIL;
                else if (packet_ready)
                    w_next_state = c_ST_RX_CHECK;
            end
            c_ST_RX_CHECK: begin
                if (w_rx_valid) begin
                    if (!w_rx_byte_ok)
                        w_next_state = c_ST_RX_RELEASE;
                    else if (r_rd_addr == c_LAST_ADDR)
                        w_next_state = c_ST_RX_MAC;
                end
            end
            c_ST_RX_MAC:     if (w_rx_valid && (r_rd_addr == c_MAC_LAST)) w_next_state = c_ST_RX_RELEASE;
            c_ST_RX_RELEASE: begin
                // A match wins even if the timer ran out while checking.
                if (!packet_ready) begin
                    if (r_match)
                        w_next_state = c_ST_DONE_OK;
                    else if (w_expired)
                        w_next_state = w_retry_left ? c_ST_TX_WRITE : c_ST_DONE_FAIL;
                    else
                        w_next_state = c_ST_WAIT_REPLY;
                end
            end
            c_ST_DONE_OK:    w_next_state = c_ST_IDLE;
            c_ST_DONE_FAIL:  w_next_state = c_ST_IDLE;
            default:         w_next_state = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge mac_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= c_ST_IDLE;
            r_tx_addr   <= 6'd0;
            r_rd_addr   <= 6'd0;
            r_wait      <= 2'd0;
            r_timer     <= 24'd0;
            r_retry     <= 8'd0;
            r_target_ip <= 32'd0;
            r_match     <= 1'b0;
            r_ok        <= 1'b0;
            r_mac       <= 48'd0;
        end else begin
            r_state <= w_next_state;
            if (w_timing && !w_expired)
                r_timer <= r_timer + 24'd1;
            case (r_state)
                c_ST_IDLE: begin
                    if (req) begin
                        r_target_ip <= target_ip;
                        r_ok        <= 1'b0;
                        r_retry     <= 8'd0;
                        r_tx_addr   <= 6'd0;
                    end
                end
                c_ST_TX_NEXT: begin
                    if (r_tx_addr == c_LAST_ADDR)
                        r_timer <= 24'd0;
                    else
                        r_tx_addr <= r_tx_addr + 6'd1;
                end
                c_ST_WAIT_REPLY: begin
                    if (w_next_state == c_ST_RX_CHECK) begin
                        r_rd_addr <= c_OFF_ETHERTYPE;
                        r_wait    <= 2'd0;
                        r_match   <= 1'b0;
                    end
                end
                c_ST_RX_CHECK: begin
                    if (!w_rx_valid) begin
                        r_wait <= r_wait + 2'd1;
                    end else if (w_rx_byte_ok) begin
                        r_wait    <= 2'd0;
                        r_rd_addr <= (r_rd_addr == c_LAST_ADDR) ? c_OFF_SHA : arp_next_check(r_rd_addr);
                    end
                end
                c_ST_RX_MAC: begin
                    if (!w_rx_valid) begin
                        r_wait <= r_wait + 2'd1;
                    end else begin
                        r_mac  <= {r_mac[39:0], packet_data};
                        r_wait <= 2'd0;
                        if (r_rd_addr == c_MAC_LAST)
                            r_match <= 1'b1;
                        else
                            r_rd_addr <= r_rd_addr + 6'd1;
                    end
                end
                c_ST_RX_RELEASE: begin
                    if (w_next_state == c_ST_DONE_OK)
                        r_ok <= 1'b1;
                end
                default: ;
            endcase
            if (w_restart) begin
                r_retry   <= r_retry + 8'd1;
                r_tx_addr <= 6'd0;
            end
        end
    end

    assign busy             = (r_state != c_ST_IDLE) && (r_state != c_ST_DONE_OK) &&
                              (r_state != c_ST_DONE_FAIL);
    assign done             = (r_state == c_ST_DONE_OK) || (r_state == c_ST_DONE_FAIL);
    assign ok               = r_ok;
    assign resolved_mac     = r_mac;
    assign packet_out_we    = (r_state == c_ST_TX_WRITE);
    assign packet_out       = packet_out_we ? w_tx_byte : 8'h00;
    assign packet_out_addr  = r_tx_addr;
    assign packet_xmit      = (r_state == c_ST_TX_NEXT) && (r_tx_addr == c_LAST_ADDR);
    assign packet_read_addr = r_rd_addr;
    assign done_with_packet = (r_state == c_ST_RX_RELEASE);

endmodule
`default_nettype wire

// File: tb/tb_arp_requester.sv
`default_nettype none
// ============================================================================
// Module   : tb_arp_requester
// Purpose  : Self-checking bench for arp_requester against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_arp_requester;
    localparam int TIMEOUT  = 200;
    localparam int RETRIES  = 3;
    localparam int XMIT_GAP = TIMEOUT + 2 * 42;

    logic        mac_clk = 1'b0;
    logic        reset_n;
    logic        req;
    logic [31:0] target_ip;
    logic [47:0] myMAC;
    logic [31:0] myIP;
    logic        busy, done, ok;
    logic [47:0] resolved_mac;
    logic [7:0]  packet_out;
    logic [5:0]  packet_out_addr;
    logic        packet_out_we, packet_xmit;
    logic        packet_ready;
    logic [5:0]  packet_read_addr;
    logic [7:0]  packet_data;
    logic        done_with_packet;

    always #4 mac_clk = ~mac_clk;

    arp_requester #(.TIMEOUT_CYCLES(TIMEOUT), .MAX_RETRIES(RETRIES)) dut (
        .mac_clk(mac_clk), .reset_n(reset_n), .req(req), .target_ip(target_ip),
        .myMAC(myMAC), .myIP(myIP), .busy(busy), .done(done), .ok(ok),
        .resolved_mac(resolved_mac), .packet_out(packet_out),
        .packet_out_addr(packet_out_addr), .packet_out_we(packet_out_we),
        .packet_xmit(packet_xmit), .packet_ready(packet_ready),
        .packet_read_addr(packet_read_addr), .packet_data(packet_data),
        .done_with_packet(done_with_packet)
    );

    int checks = 0;
    int errors = 0;
    int rel_cnt = 0;

    // RX buffer with two cycles of read latency
    logic [7:0] rx_mem [64];
    logic [7:0] rx_d1;
    always @(posedge mac_clk) begin
        rx_d1       <= rx_mem[packet_read_addr];
        packet_data <= rx_d1;
    end

    int cyc = 0;
    always @(posedge mac_clk) cyc <= cyc + 1;

    logic [7:0]  tx_mem [64];
    logic [5:0]  wr_log [1024];
    int          xmit_cyc [16];
    int          wr_cnt = 0, xmit_cnt = 0, done_cnt = 0;
    logic        done_ok;
    logic [47:0] done_mac;
    always @(negedge mac_clk) begin
        if (packet_out_we) begin
            tx_mem[packet_out_addr] <= packet_out;
            wr_log[wr_cnt[9:0]]     <= packet_out_addr;
            wr_cnt                  <= wr_cnt + 1;
        end
        if (packet_xmit) begin
            xmit_cyc[xmit_cnt[3:0]] <= cyc;
            xmit_cnt                <= xmit_cnt + 1;
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_ok  <= ok;
            done_mac <= resolved_mac;
        end
    end

    function automatic logic [335:0] req_frame(input logic [47:0] mac, input logic [31:0] ip,
                                               input logic [31:0] tip);
        return {48'hFFFF_FFFF_FFFF, mac, 16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04,
                16'h0001, mac, ip, 48'h0, tip};
    endfunction

    function automatic logic [335:0] arp_pkt(input logic [47:0] dst, input logic [47:0] sha,
                                             input logic [31:0] spa, input logic [47:0] tha,
                                             input logic [31:0] tpa, input logic [15:0] oper);
        return {dst, sha, 16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04, oper, sha, spa, tha, tpa};
    endfunction

    function automatic logic [335:0] tx_frame();
        logic [335:0] f;
        f = '0;
        for (int i = 0; i < 42; i++) f[(41 - i) * 8 +: 8] = tx_mem[i];
        return f;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_frame(input string tag, input logic [335:0] obs, input logic [335:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge mac_clk);
        #1;
    endtask

    task automatic pulse_req(input logic [31:0] ip);
        @(negedge mac_clk);
        req = 1'b1;
        target_ip = ip;
        @(negedge mac_clk);
        req = 1'b0;
        #1;
    endtask

    task automatic wait_xmit(input int prev, input int limit);
        int n;
        n = 0;
        while (xmit_cnt == prev && n < limit) begin
            @(negedge mac_clk);
            #1;
            n++;
        end
        chk("xmit_wait", 64'(xmit_cnt != prev), 64'd1);
    endtask

    task automatic wait_done(input int prev, input int limit);
        int n;
        n = 0;
        while (done_cnt == prev && n < limit) begin
            @(negedge mac_clk);
            #1;
            n++;
        end
        chk("done_wait", 64'(done_cnt != prev), 64'd1);
    endtask

    task automatic present(input logic [335:0] f);
        int n;
        for (int i = 0; i < 64; i++) rx_mem[i] = 8'h00;
        for (int i = 0; i < 42; i++) rx_mem[i] = f[(41 - i) * 8 +: 8];
        @(negedge mac_clk);
        packet_ready = 1'b1;
        n = 0;
        #1;
        while (!done_with_packet && n < 1000) begin
            @(negedge mac_clk);
            #1;
            n++;
        end
        chk("release", 64'(done_with_packet), 64'd1);
        packet_ready = 1'b0;
        rel_cnt++;
    endtask

    initial begin
        logic [31:0] tip, tip_b;
        logic [47:0] sha, last_mac;
        int w0, x0, d0, r0, n, gap;

        reset_n = 1'b0; req = 1'b0; target_ip = '0; packet_ready = 1'b0;
        myMAC = {16'($urandom), $urandom}; myIP = 32'hC0A8_0002;
        for (int i = 0; i < 64; i++) rx_mem[i] = 8'h00;
        tick(3);

        // Reset state
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_ok", 64'(ok), 64'd0);
        chk("rst_mac", 64'(resolved_mac), 64'd0);
        chk("rst_we", 64'(packet_out_we), 64'd0);
        chk("rst_xmit", 64'(packet_xmit), 64'd0);
        chk("rst_dwp", 64'(done_with_packet), 64'd0);
        chk("rst_pout", 64'(packet_out), 64'd0);
        chk("rst_rdaddr", 64'(packet_read_addr), 64'd0);
        @(negedge mac_clk);
        reset_n = 1'b1;

        // IDLE ignores packet_ready
        present_idle: begin
            packet_ready = 1'b1;
            tick(10);
            chk("idle_dwp", 64'(done_with_packet), 64'd0);
            chk("idle_busy", 64'(busy), 64'd0);
            packet_ready = 1'b0;
        end

        // Basic resolution
        tip = 32'hC0A8_0001;
        w0 = wr_cnt; x0 = xmit_cnt; d0 = done_cnt;
        pulse_req(tip);
        chk("t1_busy", 64'(busy), 64'd1);
        wait_xmit(x0, 500);
        chk("t1_wr_count", 64'(wr_cnt - w0), 64'd42);
        chk("t1_first_addr", 64'(wr_log[w0[9:0]]), 64'd0);
        chk_frame("t1_frame", tx_frame(), req_frame(myMAC, myIP, tip));
        chk("t1_byte21", 64'(tx_mem[21]), 64'h01);
        chk("t1_tpa", 64'({tx_mem[38], tx_mem[39], tx_mem[40], tx_mem[41]}), 64'hC0A8_0001);
        tick($urandom_range(5, 50));
        sha = 48'h0011_2233_4455;
        present(arp_pkt(myMAC, sha, tip, myMAC, myIP, 16'h0002));
        wait_done(d0, 500);
        chk("t1_ok", 64'(done_ok), 64'd1);
        chk("t1_mac", 64'(done_mac), 64'(sha));
        chk("t1_xmits", 64'(xmit_cnt - x0), 64'd1);
        tick(3);
        chk("t1_done_pulse", 64'(done_cnt - d0), 64'd1);
        chk("t1_busy_after", 64'(busy), 64'd0);
        chk("t1_mac_hold", 64'(resolved_mac), 64'(sha));

        // Wrong SPA, foreign request, then correct reply
        myIP = $urandom; tip = $urandom; sha = {16'($urandom), $urandom};
        x0 = xmit_cnt; d0 = done_cnt; r0 = rel_cnt;
        pulse_req(tip);
        wait_xmit(x0, 500);
        tick($urandom_range(1, 3));
        present(arp_pkt(myMAC, {16'($urandom), $urandom}, tip ^ 32'h8, myMAC, myIP, 16'h0002));
        chk("t2_no_done_1", 64'(done_cnt - d0), 64'd0);
        chk("t2_busy_1", 64'(busy), 64'd1);
        tick($urandom_range(1, 3));
        present(arp_pkt(48'hFFFF_FFFF_FFFF, {16'($urandom), $urandom}, $urandom, 48'h0, myIP, 16'h0001));
        chk("t2_no_done_2", 64'(done_cnt - d0), 64'd0);
        tick($urandom_range(1, 3));
        present(arp_pkt(myMAC, sha, tip, myMAC, myIP, 16'h0002));
        wait_done(d0, 500);
        chk("t2_ok", 64'(done_ok), 64'd1);
        chk("t2_mac", 64'(done_mac), 64'(sha));
        chk("t2_releases", 64'(rel_cnt - r0), 64'd3);
        chk("t2_xmits", 64'(xmit_cnt - x0), 64'd1);
        last_mac = sha;

        // No reply: retries with an ignored second req
        tip = $urandom; tip_b = ~tip;
        x0 = xmit_cnt; d0 = done_cnt;
        pulse_req(tip);
        tick(5);
        chk("t3_busy", 64'(busy), 64'd1);
        pulse_req(tip_b);
        for (int k = 0; k <= RETRIES; k++) begin
            w0 = wr_cnt;
            if (k == 0) w0 = w0 - 8;
            wait_xmit(x0 + k, XMIT_GAP * 2);
            chk_frame("t3_frame", tx_frame(), req_frame(myMAC, myIP, tip));
            if (k > 0) begin
                chk("t3_wr_count", 64'(wr_cnt - w0), 64'd42);
                gap = xmit_cyc[(x0 + k) % 16] - xmit_cyc[(x0 + k - 1) % 16];
                chk("t3_gap", 64'(gap >= XMIT_GAP - 3 && gap <= XMIT_GAP + 3), 64'd1);
            end
        end
        wait_done(d0, XMIT_GAP * 2);
        chk("t3_ok", 64'(done_ok), 64'd0);
        chk("t3_xmits", 64'(xmit_cnt - x0), 64'(RETRIES + 1));
        chk("t3_mac_unchanged", 64'(resolved_mac), 64'(last_mac));
        tick(XMIT_GAP);
        chk("t3_no_more_xmit", 64'(xmit_cnt - x0), 64'(RETRIES + 1));

        // Reset in the middle of a transmit
        x0 = xmit_cnt;
        pulse_req($urandom);
        n = 0;
        while (!(packet_out_we && packet_out_addr == 6'd20) && n < 500) begin
            @(negedge mac_clk);
            #1;
            n++;
        end
        chk("t5_reach_addr20", 64'(packet_out_we && packet_out_addr == 6'd20), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("t5_we_drop", 64'(packet_out_we), 64'd0);
        chk("t5_xmit_drop", 64'(packet_xmit), 64'd0);
        chk("t5_busy_drop", 64'(busy), 64'd0);
        tick(3);
        @(negedge mac_clk);
        reset_n = 1'b1;
        tick(5);
        chk("t5_no_xmit", 64'(xmit_cnt - x0), 64'd0);
        chk("t5_mac_cleared", 64'(resolved_mac), 64'd0);

        // Fresh frame, then a reply that lets the timer expire mid-check
        tip = $urandom; sha = {16'($urandom), $urandom};
        w0 = wr_cnt; x0 = xmit_cnt; d0 = done_cnt;
        pulse_req(tip);
        wait_xmit(x0, 500);
        chk("t6_wr_count", 64'(wr_cnt - w0), 64'd42);
        chk("t6_first_addr", 64'(wr_log[w0[9:0]]), 64'd0);
        chk_frame("t6_frame", tx_frame(), req_frame(myMAC, myIP, tip));
        tick(TIMEOUT - 30);
        present(arp_pkt(myMAC, sha, tip, myMAC, myIP, 16'h0002));
        wait_done(d0, 500);
        chk("t6_ok", 64'(done_ok), 64'd1);
        chk("t6_mac", 64'(done_mac), 64'(sha));
        tick(XMIT_GAP + 20);
        chk("t6_xmits", 64'(xmit_cnt - x0), 64'd1);
        chk("t6_idle", 64'(busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
